genius_seq_engine: RTL and testbench
====================================

Name: genius_seq_engine

Overview:
- Parametrised Genius/Simon sequence engine for the next-generation game datapath.
- Generates the colour sequence internally (LFSR), stores it, and plays it on the LEDs one step per round.
- Checks user presses step by step with a per-press timeout, and keeps round and points counters.
- Replaces the fixed 4-key / 64-bit whole-sequence compare with an N-channel, depth-parametrised FSM; the surrounding datapath drives it from a tick strobe instead of derived clocks.

Parameters:
N_CH, 4, number of keys/LEDs; legal values 2, 4, 8; SW = log2(N_CH) bits per symbol
MAX_ROUNDS, 16, sequence storage depth; RW = clog2(MAX_ROUNDS+1)
PW, 8, points counter width
ON_TICKS, 2, ticks each LED stays lit during playback (>=1)
OFF_TICKS, 1, ticks of dark gap after each played step (>=1)
TIMEOUT_TICKS, 5, ticks allowed per user press (>=1)

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin new game (accepted in IDLE, WIN, LOSE only; ignored otherwise)
tick  in  1  one-cycle game-rate strobe from the clock divider
seed  in  16  LFSR seed, sampled on accepted start
rounds_goal  in  RW  rounds needed to win, sampled on accepted start
btn  in  N_CH  synchronised press pulses, one cycle per press, active-high
leds  out  N_CH  one-hot playback output
round  out  RW  current round (sequence length)
points  out  PW  correct presses, saturating
playing  out  1  high in ADD/PLAY_ON/PLAY_OFF
awaiting  out  1  high in WAIT_IN
win  out  1  high in WIN
lose  out  1  high in LOSE

Behaviour:
- Reset (async, reset_n=0): state IDLE; leds, round, points, idx, timers = 0; all flags 0; LFSR = 16'hACE1. Sequence memory is not cleared.
- LFSR: 16-bit Galois, mask 16'hB400, advances once per ADD. A seed of 0 loads 16'hACE1. Symbol = lfsr[SW-1:0].
- Goal clamp at start: 0 becomes 1; values above MAX_ROUNDS become MAX_ROUNDS.
- States and transitions:
  - IDLE: on start, load LFSR, goal, round=0, points=0 -> ADD.
  - ADD (1 cycle): mem[round] <= symbol; advance LFSR; round++; idx=0; timer=0 -> PLAY_ON.
  - PLAY_ON: leds = onehot(mem[idx]). Timer counts ticks; at ON_TICKS -> PLAY_OFF, timer=0.
  - PLAY_OFF: leds = 0. At OFF_TICKS: if idx == round-1 -> WAIT_IN with idx=0, timer=0; else idx++ -> PLAY_ON.
  - WAIT_IN: leds = 0.
    - btn one-hot and equal to onehot(mem[idx]): points++ (saturating).
      - If idx == round-1: -> WIN if round == goal, else -> ADD.
      - Otherwise: idx++, timer=0.
    - btn non-zero and not a matching one-hot (wrong key or multiple keys) -> LOSE.
    - btn == 0 and tick: timer++; reaching TIMEOUT_TICKS -> LOSE.
  - WIN / LOSE: hold round and points; on start -> new game exactly as from IDLE.
- Simultaneous events:
  - A press in the same cycle as the timeout tick is evaluated as a press; the timeout is not taken.
  - btn outside WAIT_IN is ignored.
  - start outside IDLE/WIN/LOSE is ignored.
- Latency: the accepted start cycle moves to ADD; leds light 2 cycles after start.
- reset_n asserted mid-game: immediate return to reset values, no completion of the current step.
- Output flags are decoded from registered state; no combinational path from btn to any output.

Optional Feature:
- GENIUS_SPEEDUP_EN defined: playback on-time = max(1, ON_TICKS - (round-1)/4), i.e. 1 tick shorter every 4 rounds.
- Not defined: on-time is fixed at ON_TICKS. Everything else is identical.

Test Plan:
- Default parameters, seed=16'h0001, goal=3; replay each played symbol on btn -> round 1,2,3; WIN asserted; points=6 (1+2+3).
- Seed=0 -> first symbol equals seed=16'hACE1 run; both runs give identical leds traces.
- Round 2, press wrong key on step 0 -> LOSE next cycle; points = 1; round holds 2; leds=0.
- WAIT_IN with no press for 5 ticks -> LOSE on 5th tick. A correct press in the same cycle as the 5th tick -> no LOSE, advances.
- btn=4'b0011 in WAIT_IN -> LOSE. start pulse during PLAY_ON -> ignored, playback continues.
- reset_n low during PLAY_ON (async, mid-cycle) -> leds, round, points = 0 and state IDLE immediately. With GENIUS_SPEEDUP_EN, ON_TICKS=3, round 9 -> LED on-time 1 tick.

Source files
------------

// File: rtl/genius_seq_engine.sv
// genius_seq_engine: Genius/Simon game sequencer. It generates symbols from an LFSR, plays them on the LEDs and checks the presses.
// Latency: a start accepted in cycle c gives ADD in c+1 and the first LED lit in c+2; a press is judged on the cycle it arrives.
// Backpressure: none. btn outside WAIT_IN and start outside IDLE/WIN/LOSE are dropped.
//
// Ports:
//   CLOCK_50, reset_n  system clock and asynchronous active-low reset
//   start              one-cycle new-game pulse; seed and rounds_goal are sampled with it
//   tick               game-rate strobe that drives the playback and timeout timers
//   btn                one-cycle press pulses, one bit per key
//   leds               one-hot playback output
//   round, points      current sequence length and saturating count of correct presses
//   playing/awaiting/win/lose  decoded from the state register
// Optional: define GENIUS_SPEEDUP_EN to shorten the LED on-time by one tick every 4 rounds (minimum 1).

module genius_seq_engine #(
  parameter int N_CH          = 4,
  parameter int MAX_ROUNDS    = 16,
  parameter int PW            = 8,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 5,
  localparam int SW = $clog2(N_CH),
  localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            start,
  input  logic            tick,
  input  logic [15:0]     seed,
  input  logic [RW-1:0]   rounds_goal,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] leds,
  output logic [RW-1:0]   round,
  output logic [PW-1:0]   points,
  output logic            playing,
  output logic            awaiting,
  output logic            win,
  output logic            lose
);

  localparam int AW     = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam int TMAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [15:0]   LFSR_INIT = 16'hACE1;
  localparam logic [15:0]   LFSR_MASK = 16'hB400;
  localparam logic [RW-1:0] R_ONE     = RW'(1);
  localparam logic [RW-1:0] R_MAX     = RW'(MAX_ROUNDS);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] T_OFF     = TW'(OFF_TICKS);
  localparam logic [TW-1:0] T_TMO     = TW'(TIMEOUT_TICKS);
  localparam logic [PW-1:0] P_ONE     = PW'(1);
  localparam logic [PW-1:0] P_MAX     = {PW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_PLAY_ON, S_PLAY_OFF, S_WAIT_IN, S_WIN, S_LOSE
  } state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [RW-1:0]   goal;
  logic [RW-1:0]   goal_clamped;
  logic [RW-1:0]   idx;
  logic [RW-1:0]   idx_nxt;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_inc;
  logic [TW-1:0]   on_lim;
  logic [SW-1:0]   mem [0:(1<<AW)-1];
  logic [SW-1:0]   sym_new;
  logic [SW-1:0]   sym_cur;
  logic [SW-1:0]   sym_first;
  logic [SW-1:0]   sym_nxt;
  logic [N_CH-1:0] exp_oh;
  logic            last_step;

  function automatic logic [N_CH-1:0] onehot(input logic [SW-1:0] s);
    logic [N_CH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  assign sym_new   = lfsr[SW-1:0];
  assign idx_nxt   = idx + R_ONE;
  assign timer_inc = timer + T_ONE;
  assign sym_cur   = mem[idx[AW-1:0]];
  assign sym_nxt   = mem[idx_nxt[AW-1:0]];
  assign sym_first = mem[{AW{1'b0}}];
  assign exp_oh    = onehot(sym_cur);
  assign last_step = (idx == (round - R_ONE));

  always_comb begin
    goal_clamped = rounds_goal;
    if (rounds_goal == '0) begin
      goal_clamped = R_ONE;
    end else if (rounds_goal > R_MAX) begin
      goal_clamped = R_MAX;
    end
  end

`ifdef GENIUS_SPEEDUP_EN
  // round is at least 1 whenever on_lim is consulted (PLAY_ON only).
  logic [RW-1:0] speed_cut;
  assign speed_cut = (round - R_ONE) >> 2;
  assign on_lim    = (32'(speed_cut) >= ON_TICKS) ? T_ONE : TW'(ON_TICKS - 32'(speed_cut));
`else
  assign on_lim = TW'(ON_TICKS);
`endif

  // The sequence store has no reset. Every entry that is read is written earlier in the same game.
  always_ff @(posedge CLOCK_50) begin
    if (state == S_ADD) begin
      mem[round[AW-1:0]] <= sym_new;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      lfsr   <= LFSR_INIT;
      goal   <= '0;
      round  <= '0;
      points <= '0;
      idx    <= '0;
      timer  <= '0;
      leds   <= '0;
    end else begin
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            lfsr   <= (seed == 16'h0000) ? LFSR_INIT : seed;
            goal   <= goal_clamped;
            round  <= '0;
            points <= '0;
            idx    <= '0;
            timer  <= '0;
            leds   <= '0;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          lfsr  <= lfsr_next;
          round <= round + R_ONE;
          idx   <= '0;
          timer <= '0;
          // In the first round mem[0] is written on this same edge, so the LED takes the fresh symbol.
          leds  <= onehot((round == '0) ? sym_new : sym_first);
          state <= S_PLAY_ON;
        end
        S_PLAY_ON: begin
          if (tick) begin
            if (timer_inc == on_lim) begin
              timer <= '0;
              leds  <= '0;
              state <= S_PLAY_OFF;
            end else begin
              timer <= timer_inc;
            end
          end
        end
        S_PLAY_OFF: begin
          if (tick) begin
            if (timer_inc == T_OFF) begin
              timer <= '0;
              if (last_step) begin
                idx   <= '0;
                state <= S_WAIT_IN;
              end else begin
                idx   <= idx_nxt;
                leds  <= onehot(sym_nxt);
                state <= S_PLAY_ON;
              end
            end else begin
              timer <= timer_inc;
            end
          end
        end
        S_WAIT_IN: begin
          // A press takes priority over a tick that arrives in the same cycle.
          if (btn != '0) begin
            if (btn == exp_oh) begin
              if (points != P_MAX) begin
                points <= points + P_ONE;
              end
              if (last_step) begin
                state <= (round == goal) ? S_WIN : S_ADD;
              end else begin
                idx   <= idx_nxt;
                timer <= '0;
              end
            end else begin
              state <= S_LOSE;
            end
          end else if (tick) begin
            if (timer_inc == T_TMO) begin
              state <= S_LOSE;
            end else begin
              timer <= timer_inc;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign playing  = (state == S_ADD) || (state == S_PLAY_ON) || (state == S_PLAY_OFF);
  assign awaiting = (state == S_WAIT_IN);
  assign win      = (state == S_WIN);
  assign lose     = (state == S_LOSE);

endmodule

// File: tb/tb_genius_seq_engine.sv
// tb_genius_seq_engine: directed game scenarios for genius_seq_engine.
// Stimulus pushes expected LED pulses and end-of-game results into queues.
// A negedge monitor pops and compares them as the DUT presents them.

module tb_genius_seq_engine;

  localparam int N_CH          = 4;
  localparam int MAX_ROUNDS    = 16;
  localparam int PW            = 8;
  localparam int ON_TICKS      = 2;
  localparam int OFF_TICKS     = 1;
  localparam int TIMEOUT_TICKS = 5;
  localparam int RW            = $clog2(MAX_ROUNDS + 1);
  localparam int WAIT_LIMIT    = 400;

  logic            CLOCK_50;
  logic            reset_n;
  logic            start;
  logic            tick;
  logic [15:0]     seed;
  logic [RW-1:0]   rounds_goal;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] leds;
  logic [RW-1:0]   round;
  logic [PW-1:0]   points;
  logic            playing;
  logic            awaiting;
  logic            win;
  logic            lose;

  genius_seq_engine #(
    .N_CH(N_CH), .MAX_ROUNDS(MAX_ROUNDS), .PW(PW),
    .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .tick(tick),
    .seed(seed), .rounds_goal(rounds_goal), .btn(btn),
    .leds(leds), .round(round), .points(points),
    .playing(playing), .awaiting(awaiting), .win(win), .lose(lose)
  );

  typedef struct {
    logic [N_CH-1:0] leds;
    int              dur;
  } led_exp_t;

  typedef struct {
    logic          win;
    logic          lose;
    logic [RW-1:0] round;
    logic [PW-1:0] points;
  } end_exp_t;

  led_exp_t led_q[$];
  end_exp_t end_q[$];
  int       n_checks;
  int       n_pass;
  int       seq[MAX_ROUNDS];
  int       exp_pts;

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [N_CH-1:0] oh(input int s);
    logic [N_CH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int on_time(input int r);
    int t;
    t = ON_TICKS;
`ifdef GENIUS_SPEEDUP_EN
    t = t - (r - 1) / 4;
`endif
    if (t < 1 || r < 1) t = 1;
    return t;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [N_CH-1:0] mon_leds;
    int              mon_dur;
    logic            mon_end_prev;
    led_exp_t        le;
    end_exp_t        ee;
    mon_leds     = '0;
    mon_dur      = 0;
    mon_end_prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (!reset_n) begin
        mon_dur      = 0;
        mon_end_prev = 1'b0;
      end else begin
        if (leds != '0) begin
          if (mon_dur == 0) mon_leds = leds;
          mon_dur++;
        end else if (mon_dur != 0) begin
          if (led_q.size() == 0) begin
            n_checks++;
            $display("FAIL led_unexpected: got pulse %b, expected no pulse", mon_leds);
          end else begin
            le = led_q.pop_front();
            check("led_symbol", 64'(mon_leds), 64'(le.leds));
            check("led_on_cycles", 64'(mon_dur), 64'(le.dur));
          end
          mon_dur = 0;
        end
        if ((win || lose) && !mon_end_prev) begin
          if (end_q.size() == 0) begin
            n_checks++;
            $display("FAIL end_unexpected: got win=%b lose=%b, expected no game end", win, lose);
          end else begin
            ee = end_q.pop_front();
            check("end_win", 64'(win), 64'(ee.win));
            check("end_lose", 64'(lose), 64'(ee.lose));
            check("end_round", 64'(round), 64'(ee.round));
            check("end_points", 64'(points), 64'(ee.points));
            check("end_leds_dark", 64'(leds), 64'd0);
          end
        end
        mon_end_prev = win || lose;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_for(input int what, input string nm);
    int n;
    n = 0;
    while (((what == 0) ? !awaiting : (leds == '0)) && n < WAIT_LIMIT) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= WAIT_LIMIT) begin
      n_checks++;
      $display("FAIL %s: got timeout after %0d cycles, expected event", nm, n);
    end
  endtask

  task automatic set_seq(input int a, input int b, input int c);
    seq[0] = a;
    seq[1] = b;
    seq[2] = c;
  endtask

  task automatic start_game(input logic [15:0] sd, input logic [RW-1:0] g);
    exp_pts     = 0;
    tick        = 1'b1;
    seed        = sd;
    rounds_goal = g;
    start       = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge CLOCK_50);
    tick = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // Queue the LED pulses of round r, optionally poke start mid-playback, then wait for input.
  task automatic show_round(input int r, input bit poke_start);
    led_exp_t le;
    for (int k = 0; k < r; k++) begin
      le.leds = oh(seq[k]);
      le.dur  = on_time(r);
      led_q.push_back(le);
    end
    if (poke_start) begin
      wait_for(1, "wait_leds_poke");
      seed        = 16'h1234;
      rounds_goal = RW'(1);
      start       = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      check("start_ignored_playing", 64'(playing), 64'd1);
      check("start_ignored_round", 64'(round), 64'(r));
    end
    wait_for(0, "wait_awaiting");
    check("round_at_input", 64'(round), 64'(r));
  endtask

  task automatic press_round(input int r, input int goal_eff);
    end_exp_t ee;
    for (int k = 0; k < r; k++) begin
      exp_pts++;
      if (k == r - 1 && r == goal_eff) begin
        ee.win    = 1'b1;
        ee.lose   = 1'b0;
        ee.round  = RW'(r);
        ee.points = PW'(exp_pts);
        end_q.push_back(ee);
      end
      btn = oh(seq[k]);
      @(negedge CLOCK_50);
    end
    btn = '0;
  endtask

  task automatic push_lose(input int r, input int p);
    end_exp_t ee;
    ee.win    = 1'b0;
    ee.lose   = 1'b1;
    ee.round  = RW'(r);
    ee.points = PW'(p);
    end_q.push_back(ee);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [15:0] v;
    n_checks    = 0;
    n_pass      = 0;
    exp_pts     = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    tick        = 1'b0;
    seed        = '0;
    rounds_goal = '0;
    btn         = '0;

    repeat (2) @(negedge CLOCK_50);
    check("reset_leds", 64'(leds), 64'd0);
    check("reset_round", 64'(round), 64'd0);
    check("reset_points", 64'(points), 64'd0);
    check("reset_flags", 64'({playing, awaiting, win, lose}), 64'd0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    // Seed 1, goal 3: symbols 1,0,0; first LED two cycles after start; WIN with 6 points.
    set_seq(1, 0, 0);
    start_game(16'h0001, RW'(3));
    check("add_state_playing", 64'(playing), 64'd1);
    check("add_state_leds_dark", 64'(leds), 64'd0);
    show_round(1, 1'b0);
    press_round(1, 3);
    show_round(2, 1'b0);
    press_round(2, 3);
    show_round(3, 1'b0);
    press_round(3, 3);
    check("seed1_win", 64'(win), 64'd1);
    check("seed1_points", 64'(points), 64'd6);

    // The LED latency check is made on a dedicated short game.
    set_seq(1, 0, 0);
    start_game(16'h0001, RW'(1));
    @(negedge CLOCK_50);
    check("leds_lit_2_cycles_after_start", 64'(leds), 64'b0010);
    show_round(1, 1'b0);
    press_round(1, 1);

    // Seeds ACE1 and 0 must give the same trace 1,0.
    set_seq(1, 0, 0);
    start_game(16'hACE1, RW'(2));
    show_round(1, 1'b0);
    press_round(1, 2);
    show_round(2, 1'b0);
    press_round(2, 2);
    set_seq(1, 0, 0);
    start_game(16'h0000, RW'(2));
    show_round(1, 1'b0);
    press_round(1, 2);
    show_round(2, 1'b0);
    press_round(2, 2);

    // Goal 0 is clamped to 1.
    set_seq(1, 0, 0);
    start_game(16'h0001, RW'(0));
    show_round(1, 1'b0);
    press_round(1, 1);

    // Wrong key on step 0 of round 2.
    set_seq(1, 0, 0);
    start_game(16'h0001, RW'(3));
    show_round(1, 1'b0);
    press_round(1, 3);
    show_round(2, 1'b0);
    push_lose(2, 1);
    btn = 4'b0100;
    @(negedge CLOCK_50);
    btn = '0;
    check("wrong_key_lose_next_cycle", 64'(lose), 64'd1);
    check("wrong_key_round_held", 64'(round), 64'd2);

    // Timeout: four idle ticks keep waiting and the fifth loses.
    set_seq(1, 0, 0);
    start_game(16'h0001, RW'(3));
    show_round(1, 1'b0);
    tick = 1'b0;
    repeat (4) pulse_tick();
    check("no_timeout_after_4_ticks", 64'({awaiting, lose}), 64'b10);
    push_lose(1, 0);
    tick = 1'b1;
    @(negedge CLOCK_50);
    tick = 1'b0;
    check("timeout_on_5th_tick", 64'(lose), 64'd1);

    // A press arriving with the 5th tick wins over the timeout. Then btn 0011 loses.
    set_seq(1, 0, 0);
    start_game(16'h0001, RW'(3));
    show_round(1, 1'b0);
    tick = 1'b0;
    repeat (4) pulse_tick();
    tick = 1'b1;
    btn  = oh(seq[0]);
    exp_pts++;
    @(negedge CLOCK_50);
    btn = '0;
    check("press_beats_timeout_no_lose", 64'(lose), 64'd0);
    check("press_beats_timeout_advances", 64'(playing), 64'd1);
    show_round(2, 1'b0);
    push_lose(2, 1);
    btn = 4'b0011;
    @(negedge CLOCK_50);
    btn = '0;
    check("multi_key_lose", 64'(lose), 64'd1);

    // A start during PLAY_ON is ignored. Then an async reset hits mid-playback.
    set_seq(1, 0, 0);
    start_game(16'h0001, RW'(3));
    show_round(1, 1'b1);
    press_round(1, 3);
    wait_for(1, "wait_leds_reset");
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_leds", 64'(leds), 64'd0);
    check("async_reset_round", 64'(round), 64'd0);
    check("async_reset_points", 64'(points), 64'd0);
    check("async_reset_playing", 64'(playing), 64'd0);
    @(negedge CLOCK_50);
    check("async_reset_flags", 64'({awaiting, win, lose}), 64'd0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    set_seq(1, 0, 0);
    start_game(16'h0001, RW'(1));
    show_round(1, 1'b0);
    press_round(1, 1);

    // Goal 31 is clamped to MAX_ROUNDS. Symbols come from a reference LFSR.
    v = 16'hBEEF;
    for (int k = 0; k < MAX_ROUNDS; k++) begin
      seq[k] = int'(v[1:0]);
      v      = lfsr_step(v);
    end
    start_game(16'hBEEF, RW'(31));
    for (int r = 1; r <= MAX_ROUNDS; r++) begin
      show_round(r, 1'b0);
      press_round(r, MAX_ROUNDS);
    end
    check("clamp_win", 64'(win), 64'd1);
    check("clamp_points", 64'(points), 64'd136);

    repeat (3) @(negedge CLOCK_50);
    check("led_queue_drained", 64'(led_q.size()), 64'd0);
    check("end_queue_drained", 64'(end_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
